// File: rtl/feedthru_rx_slice.sv
// feedthru_rx_slice
//   Receiving end of a feed-through valid/ready path. The stream is registered
//   in a 2-entry skid buffer, so no combinational path crosses the block.
//   in_ready, out_valid and out_data all come straight from flops. The block
//   also counts accepted beats and keeps a sticky flag for counter wrap.
//   Optional feature macro: FEEDTHRU_RX_PARITY_EN. When it is defined, the
//   par_in and par_err ports exist and the block checks even parity on each
//   accepted beat.
module feedthru_rx_slice #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  beat_cnt,
  output logic              cnt_wrap
`ifdef FEEDTHRU_RX_PARITY_EN
  ,
  input  logic              par_in,
  output logic              par_err
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   main_q, main_d;
  logic [DATA_W-1:0]   skid_q, skid_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                wrap_q, wrap_d;
  logic                accept;
  logic                drain;

  // The handshakes use only registered flags. When in_ready_q is 0, this
  // masks any value on in_valid or in_data.
  assign accept = in_valid & in_ready_q;
  assign drain  = out_valid_q & out_ready;

  // Next-state, buffer steering and output-flag decode
  always_comb begin
    // NOTE: every signal written here gets a default first. A path that
    // leaves a signal unassigned would otherwise infer a latch.
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          main_d  = in_data;
          state_d = ONE;
        end
      end
      ONE: begin
        if (accept && drain) begin
          main_d = in_data;
        end else if (accept) begin
          skid_d  = in_data;
          state_d = FULL;
        end else if (drain) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (drain) begin
          main_d  = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    in_ready_d  = (state_d != FULL);
    out_valid_d = (state_d != EMPTY);
  end

  // Beat counter and sticky wrap flag
  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = wrap_q;
    if (accept) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == {CNT_W{1'b1}}) begin
        wrap_d = 1'b1;
      end
    end
  end

  // State, buffer and flag registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      // NOTE: the payload registers are reset because out_data must read 0
      // out of reset. Without that requirement they could go without a reset.
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
      wrap_q      <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only. All flops
      // then sample pre-edge values regardless of statement order.
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      cnt_q       <= cnt_d;
      wrap_q      <= wrap_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;
  assign beat_cnt  = cnt_q;
  assign cnt_wrap  = wrap_q;

`ifdef FEEDTHRU_RX_PARITY_EN
  logic par_err_q;

  // Sticky even-parity check on each accepted beat; the payload passes unchanged
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_err_q <= 1'b0;
    end else if (accept && (^{in_data, par_in})) begin
      par_err_q <= 1'b1;
    end
  end

  assign par_err = par_err_q;
`endif

endmodule

// File: tb/tb_feedthru_rx_slice.sv
// Self-checking bench for feedthru_rx_slice.
// The reference model is a bounded FIFO with capacity 2. The driver predicts
// accepts from the model's own occupancy and pushes each accepted beat into a
// scoreboard. The monitor pops a beat and compares it on every downstream
// transfer.
module tb_feedthru_rx_slice;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready = 1'b0;
  logic [CNT_W-1:0]  beat_cnt;
  logic              cnt_wrap;
`ifdef FEEDTHRU_RX_PARITY_EN
  logic              par_in = 1'b0;
  logic              par_err;
  logic              par_bad = 1'b0;
  logic              m_perr = 1'b0;
`endif

  // Second instance with a 2-bit counter, used for the wrap test
  logic              w_valid = 1'b0;
  logic [DATA_W-1:0] w_data = '0;
  logic              w_in_ready;
  logic              w_out_valid;
  logic [DATA_W-1:0] w_out_data;
  logic [1:0]        w_beat_cnt;
  logic              w_cnt_wrap;
`ifdef FEEDTHRU_RX_PARITY_EN
  logic              w_par_err;
`endif

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // Reference model state
  logic [DATA_W-1:0] sb[$];
  int                occ = 0;
  int unsigned       m_cnt = 0;

  always #5 clk = ~clk;

  feedthru_rx_slice #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .beat_cnt  (beat_cnt),
    .cnt_wrap  (cnt_wrap)
`ifdef FEEDTHRU_RX_PARITY_EN
    ,
    .par_in    (par_in),
    .par_err   (par_err)
`endif
  );

  feedthru_rx_slice #(.DATA_W(DATA_W), .CNT_W(2)) dut_w (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (w_valid),
    .in_data   (w_data),
    .in_ready  (w_in_ready),
    .out_valid (w_out_valid),
    .out_data  (w_out_data),
    .out_ready (1'b1),
    .beat_cnt  (w_beat_cnt),
    .cnt_wrap  (w_cnt_wrap)
`ifdef FEEDTHRU_RX_PARITY_EN
    ,
    .par_in    (^w_data),
    .par_err   (w_par_err)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle. Drive the inputs, check the flags at negedge, then advance
  // the model at posedge.
  task automatic step(input logic v, input logic [DATA_W-1:0] d, input logic r);
    logic acc, drn;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
`ifdef FEEDTHRU_RX_PARITY_EN
    par_in = (^d) ^ par_bad;
`endif
    @(negedge clk);
    check("in_ready", {31'd0, in_ready}, {31'd0, occ < 2});
    check("out_valid", {31'd0, out_valid}, {31'd0, occ > 0});
    check("beat_cnt", {16'd0, beat_cnt}, m_cnt % (1 << CNT_W));
    check("cnt_wrap", {31'd0, cnt_wrap}, {31'd0, m_cnt >= (1 << CNT_W)});
`ifdef FEEDTHRU_RX_PARITY_EN
    check("par_err", {31'd0, par_err}, {31'd0, m_perr});
`endif
    @(posedge clk);
    acc = v && (occ < 2);
    drn = r && (occ > 0);
    if (acc) begin
      sb.push_back(d);
      m_cnt++;
`ifdef FEEDTHRU_RX_PARITY_EN
      if (par_bad) m_perr = 1'b1;
`endif
    end
    occ = occ + int'(acc) - int'(drn);
    #1;
  endtask

  // Monitor: pops and compares the scoreboard head on each downstream transfer
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_beat", {24'd0, out_data}, 32'hFFFF_FFFF);
        end else begin
          check("out_data", {24'd0, out_data}, {24'd0, sb.pop_front()});
        end
      end
    end
  end

  // Watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset values while rst is held
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {24'd0, out_data}, 32'd0);
    check("rst_beat_cnt", {16'd0, beat_cnt}, 32'd0);
    check("rst_cnt_wrap", {31'd0, cnt_wrap}, 32'd0);
    rst = 1'b0;

    // out_ready toggling while EMPTY has no effect
    step(1'b0, 8'h33, 1'b1);
    step(1'b0, 8'h44, 1'b0);
    step(1'b0, 8'h55, 1'b1);

    // T2: back-to-back stream 0x01..0x10 with out_ready held high
    for (int i = 1; i <= 16; i++) step(1'b1, 8'(i), 1'b1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    check("t2_beat_cnt", {16'd0, beat_cnt}, 32'd16);

    // T3: backpressure. A5 and 5A fill the buffer, so FF is held off.
    step(1'b1, 8'hA5, 1'b0);
    step(1'b1, 8'h5A, 1'b0);
    step(1'b1, 8'hFF, 1'b0);
    step(1'b1, 8'hFF, 1'b0);
    step(1'b1, 8'hFF, 1'b1);
    step(1'b1, 8'hFF, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);

    // T4: random valid/ready at 50%
    for (int i = 0; i < 1000; i++) begin
      step(1'($urandom_range(1)), 8'($urandom), 1'($urandom_range(1)));
    end
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1);
    check("t4_sb_empty", sb.size(), 32'd0);

`ifdef FEEDTHRU_RX_PARITY_EN
    // T6: 0x03 sent with par_in=1 is a parity error, and the beat is still delivered
    par_bad = 1'b1;
    step(1'b1, 8'h03, 1'b1);
    par_bad = 1'b0;
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    check("t6_par_err", {31'd0, par_err}, 32'd1);
`endif

    // T1: reset asserted while FULL
    step(1'b1, 8'h11, 1'b0);
    step(1'b1, 8'h22, 1'b0);
    @(negedge clk);
    check("t1_full_in_ready", {31'd0, in_ready}, 32'd0);
    #2;
    rst = 1'b1;
    #1;
    check("t1_in_ready", {31'd0, in_ready}, 32'd1);
    check("t1_out_valid", {31'd0, out_valid}, 32'd0);
    check("t1_beat_cnt", {16'd0, beat_cnt}, 32'd0);
    check("t1_cnt_wrap", {31'd0, cnt_wrap}, 32'd0);
    sb.delete();
    occ   = 0;
    m_cnt = 0;
`ifdef FEEDTHRU_RX_PARITY_EN
    m_perr = 1'b0;
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    // A beat offered on the first edge after release is accepted
    step(1'b1, 8'h77, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);

    // T5: 2-bit counter, five accepts; cnt_wrap is set from the 4th accept onward
    for (int k = 1; k <= 5; k++) begin
      w_valid = 1'b1;
      w_data  = 8'(k);
      @(posedge clk);
      #1;
      w_valid = 1'b0;
      @(negedge clk);
      check("t5_beat_cnt", {30'd0, w_beat_cnt}, 32'(k % 4));
      check("t5_cnt_wrap", {31'd0, w_cnt_wrap}, {31'd0, k >= 4});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
